// File: rtl/counter_ctrl4b.sv
// Sequencing controller for a WIDTH-bit up counter: start/stop, programmable
// terminal value, one-shot or periodic runs. Optional pause via COUNTER_CTRL4B_PAUSE_EN.
module counter_ctrl4b #(
  parameter int WIDTH         = 4,
  parameter int DEFAULT_LIMIT = 15
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic             Stop,
  input  logic             Mode,
  input  logic [WIDTH-1:0] Limit,
`ifdef COUNTER_CTRL4B_PAUSE_EN
  input  logic             Pause,
`endif
  output logic [WIDTH-1:0] Q,
  output logic             Busy,
  output logic             Tc,
  output logic             Done,
  output logic [1:0]       State
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_PAUSED = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  localparam logic [WIDTH-1:0] ZERO    = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
  localparam logic [WIDTH-1:0] DEF_LIM = WIDTH'(DEFAULT_LIMIT);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] limit_q, limit_d;
  logic             mode_q, mode_d;
  logic             busy_q, busy_d;
  logic             tc_q, tc_d;
  logic             done_q, done_d;
  logic             pause_s;

`ifdef COUNTER_CTRL4B_PAUSE_EN
  assign pause_s = Pause;
`else
  assign pause_s = 1'b0;
`endif

  // Next-state logic; priority is Stop, terminal action, Pause, Start.
  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    limit_d = limit_q;
    mode_d  = mode_q;
    case (state_q)
      ST_IDLE: begin
        if (Stop) begin
          q_d = ZERO;
        end else if (Start) begin
          limit_d = (Limit == ZERO) ? DEF_LIM : Limit;
          mode_d  = Mode;
          q_d     = ZERO;
          state_d = ST_RUN;
        end else begin
          q_d = q_q;
        end
      end
      ST_RUN: begin
        if (Stop) begin
          q_d     = ZERO;
          state_d = ST_IDLE;
        end else if (q_q == limit_q) begin
          if (mode_q) begin
            q_d = ZERO;
          end else begin
            state_d = ST_DONE;
          end
        end else if (pause_s) begin
          state_d = ST_PAUSED;
        end else begin
          q_d = q_q + ONE;
        end
      end
      ST_PAUSED: begin
        if (Stop) begin
          q_d     = ZERO;
          state_d = ST_IDLE;
        end else if (!pause_s) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_PAUSED;
        end
      end
      ST_DONE: begin
        if (Stop) begin
          q_d     = ZERO;
          state_d = ST_IDLE;
        end else if (Start) begin
          limit_d = (Limit == ZERO) ? DEF_LIM : Limit;
          mode_d  = Mode;
          q_d     = ZERO;
          state_d = ST_RUN;
        end else begin
          q_d = q_q;
        end
      end
      default: begin
        q_d     = ZERO;
        state_d = ST_IDLE;
      end
    endcase

    // Flags are derived from the next state so they line up with Q after the edge.
    busy_d = (state_d == ST_RUN) || (state_d == ST_PAUSED);
    tc_d   = (state_d == ST_RUN) && (q_d == limit_d);
    done_d = (state_d == ST_DONE);
  end

  // State, count and flag registers with synchronous reset.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      q_q     <= ZERO;
      limit_q <= DEF_LIM;
      mode_q  <= 1'b0;
      busy_q  <= 1'b0;
      tc_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      limit_q <= limit_d;
      mode_q  <= mode_d;
      busy_q  <= busy_d;
      tc_q    <= tc_d;
      done_q  <= done_d;
    end
  end

  assign Q     = q_q;
  assign Busy  = busy_q;
  assign Tc    = tc_q;
  assign Done  = done_q;
  assign State = state_q;

endmodule
